// File: rtl/stack_arb_pkg.sv
// Shared types and constants for the stack arbiter.
package stack_arb_pkg;

    // Encoding of req_op bits
    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;

    // Widest requester id a stored response can carry (up to 256 requesters)
    localparam int RSP_ID_W = 8;

    // Lock ownership of the shared stack
    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

    // What the arbiter remembers about the op it accepted last cycle
    typedef struct packed {
        logic [RSP_ID_W-1:0] id;
        logic                err;
        logic                pop;
    } rsp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first eligible bit at or after rr_ptr_i.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     eligible_i,
    input  logic [IDX_W-1:0] rr_ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             grant_valid_o
);

    // Walk the requesters starting at the pointer, wrapping at N, and keep the first hit
    always_comb begin
        int               idx;
        logic [IDX_W-1:0] idx_sel;
        grant_o       = '0;
        grant_idx_o   = '0;
        grant_valid_o = 1'b0;
        idx           = 0;
        idx_sel       = '0;
        for (int k = 0; k < N; k++) begin
            idx = int'(rr_ptr_i) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            idx_sel = IDX_W'(idx);
            if (!grant_valid_o && eligible_i[idx_sel]) begin
                grant_valid_o    = 1'b1;
                grant_o[idx_sel] = 1'b1;
                grant_idx_o      = idx_sel;
            end
        end
    end

endmodule

// File: rtl/stack_arbiter.sv
// Shares one stack between NUM_REQ requesters: one op per cycle, round-robin,
// response one cycle later, optional per-requester lock with idle timeout.
module stack_arbiter
    import stack_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int WORD_LEN     = 8,
    parameter int LOCK_TIMEOUT = 16,
    parameter int ID_W         = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_op,
    input  logic [NUM_REQ-1:0]           req_lock,
    input  logic [NUM_REQ*WORD_LEN-1:0]  req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         rsp_valid,
    output logic [ID_W-1:0]              rsp_id,
    output logic                         rsp_err,
    output logic [WORD_LEN-1:0]          rsp_data,
    output logic                         lock_timeout,
    output logic                         stk_push,
    output logic                         stk_pop,
    output logic [WORD_LEN-1:0]          stk_data_in,
    input  logic [WORD_LEN-1:0]          stk_data_out,
    input  logic                         stk_full,
    input  logic                         stk_empty
);

    localparam int CNT_W = $clog2(LOCK_TIMEOUT) + 1;

    logic [NUM_REQ-1:0]  eligible;
    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     grant_idx;
    logic                grant_valid;

    logic                sel_op;
    logic                sel_lock;
    logic [WORD_LEN-1:0] sel_data;
    logic                do_push;
    logic                do_pop;
    logic                reject;

    logic [ID_W-1:0]     rr_ptr_q;
    logic [ID_W-1:0]     rr_ptr_d;
    logic                rsp_valid_q;
    rsp_t                rsp_q;

    lock_state_t         state_q;
    logic [ID_W-1:0]     owner_q;
    logic [CNT_W-1:0]    idle_cnt_q;
    logic                lock_timeout_q;

    // While locked only the owner competes; nobody is eligible during reset
    always_comb begin
        eligible = '0;
        if (rstn) begin
            if (state_q == LOCKED) begin
                eligible[owner_q] = req_valid[owner_q];
            end else begin
                eligible = req_valid;
            end
        end
    end

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_rr_arbiter (
        .eligible_i    (eligible),
        .rr_ptr_i      (rr_ptr_q),
        .grant_o       (grant),
        .grant_idx_o   (grant_idx),
        .grant_valid_o (grant_valid)
    );

    // Pick out the winner's op and decide whether the stack can take it
    always_comb begin
        sel_op   = OP_PUSH;
        sel_lock = 1'b0;
        sel_data = '0;
        do_push  = 1'b0;
        do_pop   = 1'b0;
        reject   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_op   = req_op[i];
                sel_lock = req_lock[i];
                sel_data = req_data[i*WORD_LEN +: WORD_LEN];
            end
        end
        if (grant_valid) begin
            if (sel_op == OP_PUSH) begin
                if (!stk_full) begin
                    do_push = 1'b1;
                end else begin
                    reject = 1'b1;
                end
            end else begin
                if (!stk_empty) begin
                    do_pop = 1'b1;
                end else begin
                    reject = 1'b1;
                end
            end
        end
    end

    // Pointer moves just past the winner, wrapping explicitly at NUM_REQ
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_valid) begin
            if (grant_idx == ID_W'(NUM_REQ - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_idx + ID_W'(1);
            end
        end
    end

    // Remember the accepted op so its response goes out next cycle
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rr_ptr_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            rsp_valid_q <= grant_valid;
            rsp_q.id    <= RSP_ID_W'(grant_idx);
            rsp_q.err   <= reject;
            rsp_q.pop   <= do_pop;
        end
    end

    // Lock ownership: taken on a locking op, dropped on a non-locking owner op or after too long idle
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q        <= UNLOCKED;
            owner_q        <= '0;
            idle_cnt_q     <= '0;
            lock_timeout_q <= 1'b0;
        end else begin
            lock_timeout_q <= 1'b0;
            case (state_q)
                UNLOCKED: begin
                    idle_cnt_q <= '0;
                    if (grant_valid && sel_lock) begin
                        state_q <= LOCKED;
                        owner_q <= grant_idx;
                    end
                end
                LOCKED: begin
                    if (grant_valid) begin
                        idle_cnt_q <= '0;
                        if (!sel_lock) begin
                            state_q <= UNLOCKED;
                        end
                    end else if (idle_cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                        state_q        <= UNLOCKED;
                        idle_cnt_q     <= '0;
                        lock_timeout_q <= 1'b1;
                    end else begin
                        idle_cnt_q <= idle_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= UNLOCKED;
                end
            endcase
        end
    end

    // Narrow the stored response id back to the port width
    always_comb begin
        rsp_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rsp_q.id == RSP_ID_W'(i)) begin
                rsp_id = ID_W'(i);
            end
        end
    end

    assign req_ready    = grant;
    assign stk_push     = do_push;
    assign stk_pop      = do_pop;
    assign stk_data_in  = do_push ? sel_data : '0;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_err      = rsp_q.err;
    assign rsp_data     = (rstn && rsp_q.pop) ? stk_data_out : '0;
    assign lock_timeout = lock_timeout_q;

endmodule

// File: tb/tb_stack_arbiter.sv
// Bench for stack_arbiter: emulates an 8-deep stack and predicts the arbiter
// from its rules (round-robin order, queue-based stack, lock bookkeeping).
module tb_stack_arbiter;

    localparam int NUM_REQ      = 4;
    localparam int WORD_LEN     = 8;
    localparam int LOCK_TIMEOUT = 16;
    localparam int DEPTH        = 8;

    logic                        clk = 1'b0;
    logic                        rstn = 1'b0;
    logic [NUM_REQ-1:0]          req_valid = '0;
    logic [NUM_REQ-1:0]          req_op = '0;
    logic [NUM_REQ-1:0]          req_lock = '0;
    logic [NUM_REQ*WORD_LEN-1:0] req_data = '0;
    logic [NUM_REQ-1:0]          req_ready;
    logic                        rsp_valid;
    logic [1:0]                  rsp_id;
    logic                        rsp_err;
    logic [WORD_LEN-1:0]         rsp_data;
    logic                        lock_timeout;
    logic                        stk_push;
    logic                        stk_pop;
    logic [WORD_LEN-1:0]         stk_data_in;
    logic [WORD_LEN-1:0]         stk_data_out = '0;
    logic                        stk_full;
    logic                        stk_empty;

    int checks = 0;
    int errors = 0;

    // Stack emulator driven by the DUT strobes
    logic                stack_clear = 1'b1;
    int                  stk_cnt = 0;
    logic [WORD_LEN-1:0] stk_mem [DEPTH];

    // Reference model state
    int                  m_ptr = 0;
    int                  m_owner = 0;
    int                  m_idle = 0;
    bit                  m_locked = 0;
    logic [WORD_LEN-1:0] m_stk [$];
    bit                  e_rv = 0;
    bit                  e_err = 0;
    bit                  e_to = 0;
    int                  e_id = 0;
    logic [WORD_LEN-1:0] e_data = '0;

    stack_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .WORD_LEN     (WORD_LEN),
        .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .req_valid    (req_valid),
        .req_op       (req_op),
        .req_lock     (req_lock),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_id       (rsp_id),
        .rsp_err      (rsp_err),
        .rsp_data     (rsp_data),
        .lock_timeout (lock_timeout),
        .stk_push     (stk_push),
        .stk_pop      (stk_pop),
        .stk_data_in  (stk_data_in),
        .stk_data_out (stk_data_out),
        .stk_full     (stk_full),
        .stk_empty    (stk_empty)
    );

    always #5 clk = ~clk;

    // Behavioural stack with registered read data
    always @(posedge clk) begin
        if (stack_clear) begin
            stk_cnt <= 0;
        end else if (stk_push && stk_cnt < DEPTH) begin
            stk_mem[stk_cnt] <= stk_data_in;
            stk_cnt <= stk_cnt + 1;
        end else if (stk_pop && stk_cnt > 0) begin
            stk_data_out <= stk_mem[stk_cnt-1];
            stk_cnt <= stk_cnt - 1;
        end
    end
    assign stk_full  = (stk_cnt == DEPTH);
    assign stk_empty = (stk_cnt == 0);

    // Which requester should win with the current inputs (-1 for none)
    function automatic int model_grant();
        if (!rstn) return -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            int i;
            i = (m_ptr + k) % NUM_REQ;
            if (req_valid[i] && (!m_locked || i == m_owner)) return i;
        end
        return -1;
    endfunction

    // Advance one clock and fold the accepted op into the model
    task automatic tick();
        int g;
        g = model_grant();
        @(posedge clk);
        e_to = 0;
        if (!rstn) begin
            m_ptr = 0; m_locked = 0; m_owner = 0; m_idle = 0;
            e_rv = 0; e_err = 0; e_id = 0; e_data = '0;
        end else begin
            e_rv = (g >= 0); e_err = 0; e_data = '0;
            e_id = (g >= 0) ? g : 0;
            if (g >= 0) begin
                if (req_op[g] == 1'b0) begin
                    if (m_stk.size() < DEPTH) m_stk.push_back(req_data[g*WORD_LEN +: WORD_LEN]);
                    else e_err = 1;
                end else begin
                    if (m_stk.size() > 0) e_data = m_stk.pop_back();
                    else e_err = 1;
                end
                if (!m_locked) begin
                    if (req_lock[g]) begin m_locked = 1; m_owner = g; m_idle = 0; end
                end else begin
                    m_idle = 0;
                    if (!req_lock[g]) m_locked = 0;
                end
                m_ptr = (g + 1) % NUM_REQ;
            end else if (m_locked) begin
                if (m_idle == LOCK_TIMEOUT - 1) begin
                    m_locked = 0; m_idle = 0; e_to = 1;
                end else begin
                    m_idle++;
                end
            end
        end
        #1;
    endtask

    task automatic clear_stack();
        req_valid = '0;
        stack_clear = 1'b1;
        tick();
        stack_clear = 1'b0;
        m_stk.delete();
    endtask

    task automatic test_reset();
        rstn = 1'b0; stack_clear = 1'b1; req_valid = '1; req_op = 4'b1010;
        tick();
        tick();
        checks++; if (req_ready !== '0) begin errors++; $display("[TB] FAIL reset_ready got=%b exp=0000", req_ready); end
        checks++; if (stk_push !== 1'b0 || stk_pop !== 1'b0 || stk_data_in !== '0) begin errors++; $display("[TB] FAIL reset_strobes got=%b%b/%h exp=00/00", stk_push, stk_pop, stk_data_in); end
        checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_id !== 2'd0) begin errors++; $display("[TB] FAIL reset_rsp got=%b/%b/%0d exp=0/0/0", rsp_valid, rsp_err, rsp_id); end
        checks++; if (lock_timeout !== 1'b0 || rsp_data !== '0) begin errors++; $display("[TB] FAIL reset_misc got=%b/%h exp=0/00", lock_timeout, rsp_data); end
        rstn = 1'b1; stack_clear = 1'b0; req_valid = '0; req_op = '0;
    endtask

    task automatic test_push_rr();
        logic [NUM_REQ-1:0] exp;
        req_valid = '1; req_op = '0; req_lock = '0;
        for (int i = 0; i < NUM_REQ; i++) req_data[i*WORD_LEN +: WORD_LEN] = WORD_LEN'(8'h10 + i);
        for (int c = 0; c < NUM_REQ; c++) begin
            #1;
            exp = '0; exp[c] = 1'b1;
            checks++; if (req_ready !== exp) begin errors++; $display("[TB] FAIL rr_grant c=%0d got=%b exp=%b", c, req_ready, exp); end
            checks++; if (stk_push !== 1'b1 || stk_data_in !== WORD_LEN'(8'h10 + c)) begin errors++; $display("[TB] FAIL rr_push c=%0d got=%b/%h exp=1/%h", c, stk_push, stk_data_in, 8'h10 + c); end
            if (c > 0) begin
                checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(c-1) || rsp_err !== 1'b0 || rsp_data !== '0) begin errors++; $display("[TB] FAIL rr_rsp c=%0d got=%b/%0d/%b/%h exp=1/%0d/0/00", c, rsp_valid, rsp_id, rsp_err, rsp_data, c-1); end
            end
            tick();
        end
        req_valid = '0;
        #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_err !== 1'b0) begin errors++; $display("[TB] FAIL rr_rsp_last got=%b/%0d/%b exp=1/3/0", rsp_valid, rsp_id, rsp_err); end
        checks++; if (stk_cnt !== 4) begin errors++; $display("[TB] FAIL rr_depth got=%0d exp=4", stk_cnt); end
    endtask

    task automatic test_pop();
        req_valid = 4'b0100; req_op = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100 || stk_pop !== 1'b1 || stk_push !== 1'b0) begin errors++; $display("[TB] FAIL pop_grant got=%b/%b%b exp=0100/01", req_ready, stk_push, stk_pop); end
        tick();
        req_valid = '0;
        #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_err !== 1'b0 || rsp_data !== 8'h13) begin errors++; $display("[TB] FAIL pop_rsp got=%b/%0d/%b/%h exp=1/2/0/13", rsp_valid, rsp_id, rsp_err, rsp_data); end
    endtask

    task automatic test_errors();
        clear_stack();
        req_valid = 4'b0010; req_op = 4'b0010; req_lock = '0;
        #1;
        checks++; if (req_ready !== 4'b0010 || stk_pop !== 1'b0) begin errors++; $display("[TB] FAIL empty_pop_strobe got=%b/%b exp=0010/0", req_ready, stk_pop); end
        tick();
        req_valid = '0;
        #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_err !== 1'b1 || rsp_data !== '0) begin errors++; $display("[TB] FAIL empty_pop_rsp got=%b/%0d/%b/%h exp=1/1/1/00", rsp_valid, rsp_id, rsp_err, rsp_data); end
        req_op = '0;
        for (int i = 0; i < DEPTH; i++) begin
            req_valid = 4'b0001;
            req_data[WORD_LEN-1:0] = WORD_LEN'($urandom);
            #1;
            checks++; if (stk_push !== 1'b1) begin errors++; $display("[TB] FAIL fill_push i=%0d got=%b exp=1", i, stk_push); end
            tick();
        end
        req_valid = 4'b1000; req_data[3*WORD_LEN +: WORD_LEN] = 8'hAA;
        #1;
        checks++; if (req_ready !== 4'b1000 || stk_push !== 1'b0) begin errors++; $display("[TB] FAIL full_push_strobe got=%b/%b exp=1000/0", req_ready, stk_push); end
        tick();
        req_valid = '0;
        #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_err !== 1'b1 || rsp_data !== '0) begin errors++; $display("[TB] FAIL full_push_rsp got=%b/%0d/%b/%h exp=1/3/1/00", rsp_valid, rsp_id, rsp_err, rsp_data); end
        checks++; if (stk_cnt !== DEPTH) begin errors++; $display("[TB] FAIL full_depth got=%0d exp=%0d", stk_cnt, DEPTH); end
    endtask

    task automatic test_lock();
        bit lock_seq [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        req_valid = '1; req_op = 4'b0001;
        for (int c = 0; c < 4; c++) begin
            req_lock = {3'b000, lock_seq[c]};
            #1;
            checks++; if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL lock_grant c=%0d got=%b exp=0001", c, req_ready); end
            if (c > 0) begin
                checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== e_data) begin errors++; $display("[TB] FAIL lock_rsp c=%0d got=%b/%0d/%h exp=1/0/%h", c, rsp_valid, rsp_id, rsp_data, e_data); end
            end
            tick();
        end
        req_lock = '0;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("[TB] FAIL lock_release_grant got=%b exp=0010", req_ready); end
        checks++; if (rsp_id !== 2'd0 || rsp_data !== e_data) begin errors++; $display("[TB] FAIL lock_last_rsp got=%0d/%h exp=0/%h", rsp_id, rsp_data, e_data); end
        req_valid = '0;
        tick();
    endtask

    task automatic test_timeout();
        int found;
        found = -1;
        req_valid = 4'b0001; req_op = '0; req_lock = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL to_lock_grant got=%b exp=0001", req_ready); end
        tick();
        req_valid = 4'b0010; req_lock = '0;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (lock_timeout === 1'b1) begin
                found = k;
                break;
            end
            checks++; if (req_ready !== '0) begin errors++; $display("[TB] FAIL to_hold_ready k=%0d got=%b exp=0000", k, req_ready); end
            tick();
        end
        checks++; if (found != LOCK_TIMEOUT) begin errors++; $display("[TB] FAIL to_latency got=%0d exp=%0d", found, LOCK_TIMEOUT); end
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("[TB] FAIL to_after_grant got=%b exp=0010", req_ready); end
        tick();
        req_valid = '0;
        #1;
        checks++; if (lock_timeout !== 1'b0) begin errors++; $display("[TB] FAIL to_pulse_width got=%b exp=0", lock_timeout); end
    endtask

    task automatic test_reset_mid();
        req_valid = 4'b0001; req_op = '0; req_lock = 4'b0001;
        tick();
        req_op = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001 || stk_pop !== 1'b1) begin errors++; $display("[TB] FAIL rm_pop got=%b/%b exp=0001/1", req_ready, stk_pop); end
        tick();
        rstn = 1'b0; req_valid = '1;
        #1;
        checks++; if (req_ready !== '0 || stk_push !== 1'b0 || stk_pop !== 1'b0 || rsp_data !== '0) begin errors++; $display("[TB] FAIL rm_during got=%b/%b%b/%h exp=0000/00/00", req_ready, stk_push, stk_pop, rsp_data); end
        tick();
        rstn = 1'b1; req_valid = 4'b1110; req_lock = '0;
        #1;
        checks++; if (rsp_valid !== 1'b0 || lock_timeout !== 1'b0) begin errors++; $display("[TB] FAIL rm_rsp_drop got=%b/%b exp=0/0", rsp_valid, lock_timeout); end
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("[TB] FAIL rm_unlocked got=%b exp=0010", req_ready); end
        req_valid = 4'b1111;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL rm_ptr got=%b exp=0001", req_ready); end
        req_valid = '0;
        tick();
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 600; cyc++) begin
            int g;
            bit quiet, exp_push, exp_pop;
            logic [NUM_REQ-1:0] exp_ready;
            logic [WORD_LEN-1:0] exp_rdata;
            quiet = ((cyc / 40) % 2) == 1;
            rstn = ($urandom_range(0, 99) != 0);
            for (int i = 0; i < NUM_REQ; i++) begin
                req_valid[i] = ($urandom_range(0, 7) < (quiet ? 1 : 5));
                req_lock[i]  = ($urandom_range(0, 3) == 0);
            end
            req_op   = NUM_REQ'($urandom);
            req_data = $urandom;
            #1;
            g = model_grant();
            exp_ready = '0;
            exp_push = 0; exp_pop = 0;
            if (g >= 0) begin
                exp_ready[g] = 1'b1;
                exp_push = !req_op[g] && (m_stk.size() < DEPTH);
                exp_pop  = req_op[g] && (m_stk.size() > 0);
            end
            exp_rdata = rstn ? e_data : '0;
            checks++; if (req_ready !== exp_ready) begin errors++; $display("[TB] FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_ready); end
            checks++; if (stk_push !== exp_push || stk_pop !== exp_pop) begin errors++; $display("[TB] FAIL rnd_strobe cyc=%0d got=%b%b exp=%b%b", cyc, stk_push, stk_pop, exp_push, exp_pop); end
            if (exp_push) begin
                checks++; if (stk_data_in !== req_data[g*WORD_LEN +: WORD_LEN]) begin errors++; $display("[TB] FAIL rnd_din cyc=%0d got=%h exp=%h", cyc, stk_data_in, req_data[g*WORD_LEN +: WORD_LEN]); end
            end
            checks++; if (rsp_valid !== e_rv) begin errors++; $display("[TB] FAIL rnd_rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, e_rv); end
            if (e_rv) begin
                checks++; if (rsp_id !== 2'(e_id) || rsp_err !== e_err) begin errors++; $display("[TB] FAIL rnd_rsp cyc=%0d got=%0d/%b exp=%0d/%b", cyc, rsp_id, rsp_err, e_id, e_err); end
            end
            checks++; if (rsp_data !== exp_rdata) begin errors++; $display("[TB] FAIL rnd_rdata cyc=%0d got=%h exp=%h", cyc, rsp_data, exp_rdata); end
            checks++; if (lock_timeout !== e_to) begin errors++; $display("[TB] FAIL rnd_timeout cyc=%0d got=%b exp=%b", cyc, lock_timeout, e_to); end
            tick();
        end
        rstn = 1'b1; req_valid = '0;
    endtask

    // Hard stop in case something stalls the sequence
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_push_rr();
        test_pop();
        test_errors();
        test_lock();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
